// File: rtl/uart_rx_cfg_if.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg_if
// Signal bundle between the configurable UART receiver and its user.
//   rx_in             : asynchronous serial line, idle high
//   error_clear       : clears the sticky error flags
//   data_out          : last correctly framed word (LSB first on the line)
//   valid_out         : one-cycle pulse, data_out has just been updated
//   parity_error_out  : sticky parity error
//   framing_error_out : sticky framing error
//   break_out         : one-cycle pulse, line break detected
//   busy_out          : receiver is not idle
// Modports: master = receiver side, slave = user side.
// ---------------------------------------------------------------------------
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_in;
  logic                 error_clear;
  logic [DATA_BITS-1:0] data_out;
  logic                 valid_out;
  logic                 parity_error_out;
  logic                 framing_error_out;
  logic                 break_out;
  logic                 busy_out;

  modport master (
    input  rx_in, error_clear,
    output data_out, valid_out, parity_error_out, framing_error_out,
           break_out, busy_out
  );

  modport slave (
    output rx_in, error_clear,
    input  data_out, valid_out, parity_error_out, framing_error_out,
           break_out, busy_out
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg
// Configurable UART receiver: 5..9 data bits, none/even/odd parity, 1 or 2
// stop bits. Every bit is sampled three times around its centre and decided
// by 2-of-3 majority. Detects false starts, parity errors, framing errors and
// line breaks.
// Ports:
//   clock : single clock, rising edge
//   reset : synchronous, active-high
//   rx_if : uart_rx_cfg_if.master (serial input, error_clear, results)
// ---------------------------------------------------------------------------
`ifndef CLOCK_FREQUENCY
`define CLOCK_FREQUENCY 50000000
`endif
`ifndef BAUD_RATE
`define BAUD_RATE 115200
`endif

module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = `CLOCK_FREQUENCY / `BAUD_RATE,  // >= 8
  parameter int DATA_BITS    = 8,                              // 5..9
  parameter int PARITY       = 0,                              // 0 none, 1 even, 2 odd
  parameter int STOP_BITS    = 1                               // 1 or 2
) (
  input logic           clock,
  input logic           reset,
  uart_rx_cfg_if.master rx_if
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int H  = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(H);
  localparam logic [CW-1:0] CNT_VOTE = CW'(H + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  state_t               state, next_state;
  logic                 rx_meta, rxs;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic                 samp0, samp1;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 stop_bad;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, break_q, perr_q, ferr_q;

  // Decoded events
  logic vote, at_vote, at_end, last_stop, stop_good, word_zero, parity_ok;
  logic frame_done, accept, brk, perr_set, ferr_set, busy, in_bit_state;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned; otherwise a latch would be inferred.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (!rxs) next_state = S_START;
      S_START: begin
        if (at_vote && vote) next_state = S_IDLE;   // false start
        else if (at_end)     next_state = S_DATA;
      end
      S_DATA:      if (at_end && bit_idx == IDX_LAST)
                     next_state = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY:    if (at_end) next_state = S_STOP;
      // Leave half a bit early so the next start edge is not missed.
      S_STOP:      if (at_vote && last_stop)
                     next_state = stop_good ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rxs) next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / event decode
  // -------------------------------------------------------------------------
  always_comb begin
    vote       = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);
    at_vote    = (cnt == CNT_VOTE);
    at_end     = (cnt == CNT_LAST);
    last_stop  = (stop_idx == STOP_LAST);
    stop_good  = !stop_bad && vote;
    word_zero  = (shreg == '0) && ((PARITY == 0) || !par_bit);
    case (PARITY)
      1:       parity_ok = ~(^shreg ^ par_bit);
      2:       parity_ok =  (^shreg ^ par_bit);
      default: parity_ok = 1'b1;
    endcase
    frame_done   = (state == S_STOP) && at_vote && last_stop;
    accept       = frame_done && stop_good;
    brk          = frame_done && !stop_good && word_zero;
    perr_set     = accept && !parity_ok;
    busy         = (state != S_IDLE);
    in_bit_state = 1'b0;
    ferr_set     = frame_done && !stop_good && !word_zero;
    case (state)
      S_IDLE, S_WAIT_HIGH: ;
      S_START, S_DATA, S_PARITY, S_STOP: in_bit_state = 1'b1;
      default: ferr_set = 1'b1;                    // corrupted state register
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      // Synchronizer resets to the idle line level so no false start follows.
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      samp0    <= 1'b1;
      samp1    <= 1'b1;
      shreg    <= '0;
      par_bit  <= 1'b0;
      stop_bad <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      break_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      rx_meta <= rx_if.rx_in;
      rxs     <= rx_meta;

      valid_q <= accept;
      break_q <= brk;
      if (accept) data_q <= shreg;
      // A flag being set in the same cycle as error_clear stays set.
      perr_q <= (perr_q & ~rx_if.error_clear) | perr_set;
      ferr_q <= (ferr_q & ~rx_if.error_clear) | ferr_set;

      // Bit-window counter restarts at every bit boundary and state change.
      if (in_bit_state && (next_state == state) && !at_end) cnt <= cnt + 1'b1;
      else                                                  cnt <= '0;

      if (cnt == CNT_S0) samp0 <= rxs;
      if (cnt == CNT_S1) samp1 <= rxs;

      case (state)
        S_START: begin
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          stop_bad <= 1'b0;
        end
        S_DATA: begin
          if (at_vote) shreg   <= {vote, shreg[DATA_BITS-1:1]};
          if (at_end)  bit_idx <= bit_idx + 1'b1;
        end
        S_PARITY: if (at_vote) par_bit <= vote;
        S_STOP: begin
          if (at_vote && !vote) stop_bad <= 1'b1;
          if (at_end)           stop_idx <= stop_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rx_if.data_out          = data_q;
  assign rx_if.valid_out         = valid_q;
  assign rx_if.break_out         = break_q;
  assign rx_if.parity_error_out  = perr_q;
  assign rx_if.framing_error_out = ferr_q;
  assign rx_if.busy_out          = busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_cfg
// Directed bench for uart_rx_cfg with 16 clocks/bit, 8 data bits, even
// parity, one stop bit. Each scenario task drives the serial line bit by bit
// and compares outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_rx_cfg;

  logic clock;
  logic reset;

  uart_rx_cfg_if #(.DATA_BITS(8)) bus ();

  uart_rx_cfg #(
    .CLKS_PER_BIT(16),
    .DATA_BITS   (8),
    .PARITY      (1),
    .STOP_BITS   (1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rx_if(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Pulse monitor, sampled on the falling edge.
  int         valid_cnt = 0;
  int         break_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clock) begin
    if (bus.valid_out === 1'b1) begin
      prev_data = last_data;
      last_data = bus.data_out;
      valid_cnt++;
    end
    if (bus.break_out === 1'b1) break_cnt++;
  end

  // ---------------------------------------------------------------- stimulus
  task automatic send_bit(input logic b);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      bus.rx_in = b;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      bus.rx_in = 1'b1;
    end
    #1;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset;
    reset = 1'b1;
    bus.rx_in = 1'b1;
    bus.error_clear = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL reset_data: got=%h exp=00", bus.data_out); end
    total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got=%b exp=0", bus.valid_out); end
    total++; if (bus.parity_error_out !== 1'b0) begin bad++; $display("FAIL reset_perr: got=%b exp=0", bus.parity_error_out); end
    total++; if (bus.framing_error_out !== 1'b0) begin bad++; $display("FAIL reset_ferr: got=%b exp=0", bus.framing_error_out); end
    total++; if (bus.break_out !== 1'b0) begin bad++; $display("FAIL reset_break: got=%b exp=0", bus.break_out); end
    total++; if (bus.busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b exp=0", bus.busy_out); end
    reset = 1'b0;
    idle(8);
    total++; if (bus.busy_out !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: got=%b exp=0", bus.busy_out); end
  endtask

  task automatic test_good_frame;
    int v0, b0;
    logic [7:0] d;
    v0 = valid_cnt; b0 = break_cnt; d = 8'hA5;
    send_bit(1'b0);
    #1;
    total++; if (bus.busy_out !== 1'b1) begin bad++; $display("FAIL good_busy_mid: got=%b exp=1", bus.busy_out); end
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(1'b0);          // 0xA5 has four ones: even parity bit 0
    send_bit(1'b1);
    idle(8);
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL good_valid_count: got=%0d exp=1", valid_cnt - v0); end
    total++; if (last_data !== 8'hA5) begin bad++; $display("FAIL good_valid_data: got=%h exp=a5", last_data); end
    total++; if (bus.data_out !== 8'hA5) begin bad++; $display("FAIL good_data_out: got=%h exp=a5", bus.data_out); end
    total++; if (bus.parity_error_out !== 1'b0) begin bad++; $display("FAIL good_perr: got=%b exp=0", bus.parity_error_out); end
    total++; if (bus.framing_error_out !== 1'b0) begin bad++; $display("FAIL good_ferr: got=%b exp=0", bus.framing_error_out); end
    total++; if (break_cnt - b0 !== 0) begin bad++; $display("FAIL good_break: got=%0d exp=0", break_cnt - b0); end
    total++; if (bus.busy_out !== 1'b0) begin bad++; $display("FAIL good_busy_after: got=%b exp=0", bus.busy_out); end
  endtask

  task automatic test_parity_error;
    int v0;
    v0 = valid_cnt;
    send_frame(8'h01, 1'b0, 1'b1);   // one '1' needs parity 1; 0 is wrong
    idle(8);
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL par_valid_count: got=%0d exp=1", valid_cnt - v0); end
    total++; if (bus.data_out !== 8'h01) begin bad++; $display("FAIL par_data_out: got=%h exp=01", bus.data_out); end
    total++; if (bus.parity_error_out !== 1'b1) begin bad++; $display("FAIL par_flag_set: got=%b exp=1", bus.parity_error_out); end
    total++; if (bus.framing_error_out !== 1'b0) begin bad++; $display("FAIL par_ferr: got=%b exp=0", bus.framing_error_out); end
    idle(40);
    total++; if (bus.parity_error_out !== 1'b1) begin bad++; $display("FAIL par_flag_sticky: got=%b exp=1", bus.parity_error_out); end
    @(negedge clock); bus.error_clear = 1'b1;
    @(negedge clock); bus.error_clear = 1'b0;
    idle(2);
    total++; if (bus.parity_error_out !== 1'b0) begin bad++; $display("FAIL par_flag_cleared: got=%b exp=0", bus.parity_error_out); end
  endtask

  task automatic test_false_start;
    int v0, b0;
    v0 = valid_cnt; b0 = break_cnt;
    for (int i = 0; i < 4; i++) begin @(negedge clock); bus.rx_in = 1'b0; end
    for (int i = 0; i < 3; i++) begin @(negedge clock); bus.rx_in = 1'b1; end
    #1;
    total++; if (bus.busy_out !== 1'b1) begin bad++; $display("FAIL false_busy_mid: got=%b exp=1", bus.busy_out); end
    idle(30);
    total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL false_valid: got=%0d exp=0", valid_cnt - v0); end
    total++; if (break_cnt - b0 !== 0) begin bad++; $display("FAIL false_break: got=%0d exp=0", break_cnt - b0); end
    total++; if (bus.framing_error_out !== 1'b0) begin bad++; $display("FAIL false_ferr: got=%b exp=0", bus.framing_error_out); end
    total++; if (bus.parity_error_out !== 1'b0) begin bad++; $display("FAIL false_perr: got=%b exp=0", bus.parity_error_out); end
    total++; if (bus.busy_out !== 1'b0) begin bad++; $display("FAIL false_busy_after: got=%b exp=0", bus.busy_out); end
  endtask

  task automatic test_glitch;
    int v0;
    v0 = valid_cnt;
    send_bit(1'b0);
    // 0xFF with a one-clock low glitch landing on each of the three
    // sample points in turn (bits 1, 3 and 5).
    for (int b = 0; b < 8; b++) begin
      for (int j = 0; j < 16; j++) begin
        @(negedge clock);
        bus.rx_in = !((b == 1 && j == 8) || (b == 3 && j == 9) || (b == 5 && j == 10));
      end
    end
    send_bit(1'b0);          // eight ones: even parity bit 0
    send_bit(1'b1);
    idle(8);
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL glitch_valid: got=%0d exp=1", valid_cnt - v0); end
    total++; if (bus.data_out !== 8'hFF) begin bad++; $display("FAIL glitch_data: got=%h exp=ff", bus.data_out); end
    total++; if (bus.parity_error_out !== 1'b0) begin bad++; $display("FAIL glitch_perr: got=%b exp=0", bus.parity_error_out); end
  endtask

  task automatic test_break;
    int v0, b0;
    v0 = valid_cnt; b0 = break_cnt;
    for (int i = 0; i < 12 * 16; i++) begin @(negedge clock); bus.rx_in = 1'b0; end
    #1;
    total++; if (bus.busy_out !== 1'b1) begin bad++; $display("FAIL brk_wait_busy: got=%b exp=1", bus.busy_out); end
    total++; if (break_cnt - b0 !== 1) begin bad++; $display("FAIL brk_pulse: got=%0d exp=1", break_cnt - b0); end
    total++; if (bus.framing_error_out !== 1'b0) begin bad++; $display("FAIL brk_ferr: got=%b exp=0", bus.framing_error_out); end
    total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL brk_valid: got=%0d exp=0", valid_cnt - v0); end
    idle(32);
    total++; if (bus.busy_out !== 1'b0) begin bad++; $display("FAIL brk_idle_busy: got=%b exp=0", bus.busy_out); end
    send_frame(8'h3C, 1'b0, 1'b1);
    idle(8);
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL brk_next_valid: got=%0d exp=1", valid_cnt - v0); end
    total++; if (bus.data_out !== 8'h3C) begin bad++; $display("FAIL brk_next_data: got=%h exp=3c", bus.data_out); end
    total++; if (break_cnt - b0 !== 1) begin bad++; $display("FAIL brk_single: got=%0d exp=1", break_cnt - b0); end
    total++; if (bus.framing_error_out !== 1'b0) begin bad++; $display("FAIL brk_ferr_after: got=%b exp=0", bus.framing_error_out); end
  endtask

  task automatic test_framing;
    int v0, b0;
    logic [7:0] d;
    v0 = valid_cnt; b0 = break_cnt; d = 8'h80;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(1'b1);          // one '1': even parity bit 1
    // Bad stop bit; error_clear held high up to and including the decision
    // edge, so the new error must survive it.
    for (int j = 0; j < 16; j++) begin
      @(negedge clock);
      bus.rx_in = 1'b0;
      bus.error_clear = (j <= 12);
    end
    idle(8);
    total++; if (bus.framing_error_out !== 1'b1) begin bad++; $display("FAIL frm_flag_set: got=%b exp=1", bus.framing_error_out); end
    total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL frm_valid: got=%0d exp=0", valid_cnt - v0); end
    total++; if (bus.data_out !== 8'h3C) begin bad++; $display("FAIL frm_data_kept: got=%h exp=3c", bus.data_out); end
    total++; if (break_cnt - b0 !== 0) begin bad++; $display("FAIL frm_break: got=%0d exp=0", break_cnt - b0); end
    total++; if (bus.busy_out !== 1'b0) begin bad++; $display("FAIL frm_busy_after: got=%b exp=0", bus.busy_out); end
    @(negedge clock); bus.error_clear = 1'b1;
    @(negedge clock); bus.error_clear = 1'b0;
    idle(2);
    total++; if (bus.framing_error_out !== 1'b0) begin bad++; $display("FAIL frm_flag_cleared: got=%b exp=0", bus.framing_error_out); end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = valid_cnt;
    send_frame(8'h12, 1'b0, 1'b1);   // two ones -> parity 0
    send_frame(8'h34, 1'b1, 1'b1);   // three ones -> parity 1
    idle(8);
    total++; if (valid_cnt - v0 !== 2) begin bad++; $display("FAIL b2b_valid: got=%0d exp=2", valid_cnt - v0); end
    total++; if (prev_data !== 8'h12) begin bad++; $display("FAIL b2b_first: got=%h exp=12", prev_data); end
    total++; if (last_data !== 8'h34) begin bad++; $display("FAIL b2b_second: got=%h exp=34", last_data); end
    total++; if (bus.parity_error_out !== 1'b0) begin bad++; $display("FAIL b2b_perr: got=%b exp=0", bus.parity_error_out); end
  endtask

  task automatic test_reset_midframe;
    int v0, b0;
    logic [7:0] d;
    send_frame(8'h01, 1'b0, 1'b1);   // leave a parity error pending
    idle(4);
    total++; if (bus.parity_error_out !== 1'b1) begin bad++; $display("FAIL rst_pre_perr: got=%b exp=1", bus.parity_error_out); end
    v0 = valid_cnt; b0 = break_cnt; d = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    for (int j = 0; j < 8; j++) begin @(negedge clock); bus.rx_in = d[3]; end
    @(negedge clock);
    reset = 1'b1;
    bus.rx_in = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL rst_data: got=%h exp=00", bus.data_out); end
    total++; if (bus.parity_error_out !== 1'b0) begin bad++; $display("FAIL rst_perr: got=%b exp=0", bus.parity_error_out); end
    total++; if (bus.framing_error_out !== 1'b0) begin bad++; $display("FAIL rst_ferr: got=%b exp=0", bus.framing_error_out); end
    total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid: got=%b exp=0", bus.valid_out); end
    total++; if (bus.break_out !== 1'b0) begin bad++; $display("FAIL rst_break: got=%b exp=0", bus.break_out); end
    total++; if (bus.busy_out !== 1'b0) begin bad++; $display("FAIL rst_busy: got=%b exp=0", bus.busy_out); end
    reset = 1'b0;
    idle(40);
    total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL rst_no_valid: got=%0d exp=0", valid_cnt - v0); end
    total++; if (break_cnt - b0 !== 0) begin bad++; $display("FAIL rst_no_break: got=%0d exp=0", break_cnt - b0); end
    total++; if (bus.framing_error_out !== 1'b0) begin bad++; $display("FAIL rst_no_ferr: got=%b exp=0", bus.framing_error_out); end
    send_frame(8'h5A, 1'b0, 1'b1);   // four ones -> parity 0
    idle(8);
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL rst_next_valid: got=%0d exp=1", valid_cnt - v0); end
    total++; if (bus.data_out !== 8'h5A) begin bad++; $display("FAIL rst_next_data: got=%h exp=5a", bus.data_out); end
  endtask

  // ------------------------------------------------------------- sequence
  initial begin
    reset = 1'b1;
    bus.rx_in = 1'b1;
    bus.error_clear = 1'b0;
    test_reset();
    test_good_frame();
    test_parity_error();
    test_false_start();
    test_glitch();
    test_break();
    test_framing();
    test_back_to_back();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default `CLOCK_FREQUENCY / `BAUD_RATE (defines.vh), clocks per bit, legal >= 8.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-003 SHALL have parameter PARITY, default 0, 0 none / 1 even / 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, legal 1 or 2.
REQ-005 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port rx_in  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port error_clear  input  1  clears sticky error flags.
REQ-009 SHALL have port data_out  output  DATA_BITS  last received word, LSB first on line.
REQ-010 SHALL have port valid_out  output  1  one-cycle pulse, data_out updated.
REQ-011 SHALL have port parity_error_out  output  1  sticky parity error.
REQ-012 SHALL have port framing_error_out  output  1  sticky framing error.
REQ-013 SHALL have port break_out  output  1  one-cycle pulse, break detected.
REQ-014 SHALL have port busy_out  output  1  high whenever state != IDLE.

Function
REQ-015 SHALL pass rx_in through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; PARITY skipped when PARITY=0.
REQ-017 IDLE: rxs==0 SHALL enter START with bit counter 0; each bit window then spans counter 0..CLKS_PER_BIT-1, H = CLKS_PER_BIT/2.
REQ-018 Each bit SHALL be sampled at counter H-1, H, H+1; bit value = 2-of-3 majority, decided at counter H+1.
REQ-019 START: vote 1 SHALL return to IDLE at H+1 with no flag, no pulse (false start); vote 0 continues.
REQ-020 State SHALL advance to next bit at counter CLKS_PER_BIT-1; counter resets to 0.
REQ-021 DATA: DATA_BITS bits SHALL be shifted in LSB first; bit index wraps to PARITY/STOP after DATA_BITS-1.
REQ-022 PARITY: even -> XOR(data, parity bit) must be 0; odd -> must be 1.
REQ-023 STOP: every stop bit vote SHALL be checked; final decision at H+1 of last stop bit.
REQ-024 Good stop, any parity: data_out <= word, valid_out pulses next cycle, state -> IDLE at that decision (half-bit early, ready for next start edge).
REQ-025 Parity mismatch with good stop SHALL still pulse valid_out and SHALL set parity_error_out.
REQ-026 Any stop vote 0 with data, parity bit all 0 SHALL pulse break_out, not set framing_error_out, not pulse valid_out, enter WAIT_HIGH.
REQ-027 Any other stop vote 0 SHALL set framing_error_out, leave data_out unchanged, no valid_out, enter WAIT_HIGH.
REQ-028 WAIT_HIGH SHALL return to IDLE on first cycle rxs==1.
REQ-029 error_clear SHALL clear both sticky flags; an error set in the same cycle wins.
REQ-030 Counter width SHALL be $clog2(CLKS_PER_BIT); no overflow at CLKS_PER_BIT-1.
REQ-031 Undefined state SHALL set framing_error_out and go to IDLE.

Reset
REQ-032 reset SHALL force state IDLE, counter 0, synchronizer flops 1, data_out 0, valid_out 0, break_out 0, both error flags 0, busy_out 0.
REQ-033 reset mid-frame SHALL abandon the frame without any pulse or flag; reset overrides error_clear and all events.

Verification (CLKS_PER_BIT=16, DATA_BITS=8, PARITY=1, STOP_BITS=1)
REQ-034 Frame 0xA5, parity 0, stop 1 -> exactly one valid_out, data_out=0xA5, flags 0, busy_out 0 after.
REQ-035 Frame 0x01, parity 0 -> valid_out, data_out=0x01, parity_error_out=1 held until error_clear, then 0.
REQ-036 rx low 4 clocks then high -> no valid_out, no flags; 1-clock glitch inside a data bit of 0xFF -> data_out=0xFF.
REQ-037 rx low 12 bit times, then high, then frame 0x3C -> one break_out, framing_error_out=0, then valid_out with 0x3C.
REQ-038 Frame 0x80 with stop bit 0 -> framing_error_out=1, no valid_out, data_out unchanged.
REQ-039 reset during data bit 3, then frame 0x5A -> all outputs 0 after reset, then valid_out with data_out=0x5A.
